// File: rtl/life_row_scanner.sv
// Row-multiplexed display scanner for an 8x8 Life grid: double-buffered grid
// intake, one lit row at a time with a one-cycle blank between rows.
module life_row_scanner #(
    parameter int ROW_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [15:0] gen_count,
    output logic        stable,
    output logic        extinct
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  row_reg, row_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [63:0] shadow_reg, active_reg, active_next;
    logic        shadow_full_reg;
    logic        swap, accept;
    logic [15:0] gen_count_reg;
    logic        stable_reg, extinct_reg;
    logic [7:0]  row_sel_reg, row_sel_next;
    logic [7:0]  col_data_reg, col_data_next;
    logic        frame_done_reg, frame_done_next;
    logic [7:0]  row_bits [8];

    assign grid_ready = ~shadow_full_reg;
    assign accept     = grid_valid & ~shadow_full_reg;
    assign row_sel    = row_sel_reg;
    assign col_data   = col_data_reg;
    assign frame_done = frame_done_reg;
    assign gen_count  = gen_count_reg;
    assign stable     = stable_reg;
    assign extinct    = extinct_reg;

    assign active_next = swap ? shadow_reg : active_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rows
            assign row_bits[gi] = active_next[63-8*gi -: 8];
        end
    endgenerate

    // Display outputs are registered from the post-edge state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            row_reg        <= 3'd0;
            cnt_reg        <= 16'd0;
            row_sel_reg    <= 8'h00;
            col_data_reg   <= 8'h00;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            cnt_reg        <= cnt_next;
            row_sel_reg    <= row_sel_next;
            col_data_reg   <= col_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        swap       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (shadow_full_reg) begin
                    swap       = 1'b1;
                    row_next   = 3'd0;
                    cnt_next   = 16'd0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                cnt_next = cnt_reg + 16'd1;
                if (cnt_reg == 16'(ROW_DIV - 1)) begin
                    cnt_next   = 16'd0;
                    state_next = BLANK;
                end
            end
            BLANK: begin
                // Row 7 wraps to 0; a pending grid is only taken at this frame boundary.
                row_next   = row_reg + 3'd1;
                cnt_next   = 16'd0;
                state_next = SCAN;
                if (row_reg == 3'd7 && shadow_full_reg)
                    swap = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        row_sel_next    = 8'h00;
        col_data_next   = 8'h00;
        frame_done_next = 1'b0;
        case (state_next)
            SCAN: begin
                row_sel_next  = 8'h01 << row_next;
                col_data_next = row_bits[row_next];
            end
            BLANK: frame_done_next = (row_next == 3'd7);
            default: ;
        endcase
    end

    // Shadow keeps the last accepted grid, which doubles as the stability reference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_reg      <= 64'd0;
            active_reg      <= 64'd0;
            shadow_full_reg <= 1'b0;
            gen_count_reg   <= 16'd0;
            stable_reg      <= 1'b0;
            extinct_reg     <= 1'b0;
        end else begin
            active_reg <= active_next;
            if (swap) begin
                shadow_full_reg <= 1'b0;
            end else if (accept) begin
                shadow_reg      <= grid_in;
                shadow_full_reg <= 1'b1;
                if (gen_count_reg != 16'hFFFF)
                    gen_count_reg <= gen_count_reg + 16'd1;
                extinct_reg <= (grid_in == 64'd0);
                stable_reg  <= (grid_in == shadow_reg) && (gen_count_reg != 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_life_row_scanner.sv
// Bench for life_row_scanner: scoreboarded row sequence, frame timing,
// frame-boundary swap, generation statistics and reset behaviour.
module tb_life_row_scanner;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] grid_in = 64'd0;
    logic        grid_valid = 1'b0;
    logic        grid_ready;
    logic [7:0]  row_sel, col_data;
    logic        frame_done;
    logic [15:0] gen_count;
    logic        stable, extinct;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] data;
    } row_t;
    row_t exp_q[$];

    localparam logic [63:0] G1 = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] G2 = 64'hFFFF_0000_FFFF_0000;

    life_row_scanner #(.ROW_DIV(RD)) dut (
        .clk(clk), .reset(reset), .grid_in(grid_in), .grid_valid(grid_valid),
        .grid_ready(grid_ready), .row_sel(row_sel), .col_data(col_data),
        .frame_done(frame_done), .gen_count(gen_count), .stable(stable),
        .extinct(extinct)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] row_of(input logic [63:0] g, input int r);
        return g[63-8*r -: 8];
    endfunction

    task automatic push_rows(input logic [63:0] g, input int first, input int last);
        for (int r = first; r <= last; r++) begin
            row_t e;
            e.sel  = 8'h01 << r;
            e.data = row_of(g, r);
            exp_q.push_back(e);
        end
    endtask

    // Consume one expected lit row: content, lit length, single blank cycle.
    task automatic drain_one();
        row_t e;
        int w, len;
        w = 0;
        while (row_sel === 8'h00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (row_sel === 8'h00 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL drain_wait: row_sel=%h queued=%0d", row_sel, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (row_sel !== e.sel || col_data !== e.data) begin
            bad++;
            $display("FAIL row: got sel=%h data=%h want sel=%h data=%h", row_sel, col_data, e.sel, e.data);
        end
        len = 0;
        while (row_sel === e.sel && len < 50) begin
            len++;
            @(negedge clk);
        end
        total++;
        if (len != RD) begin
            bad++;
            $display("FAIL row_len sel=%h: got %0d want %0d", e.sel, len, RD);
        end
        total++;
        if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_done !== (e.sel == 8'h80)) begin
            bad++;
            $display("FAIL blank: got sel=%h data=%h fd=%b want 00/00/%b", row_sel, col_data, frame_done, e.sel == 8'h80);
        end
        @(negedge clk);
        total++;
        if (row_sel === 8'h00) begin
            bad++;
            $display("FAIL blank_len: got row_sel=%h want nonzero after one blank", row_sel);
        end
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) drain_one();
    endtask

    task automatic accept(input logic [63:0] g);
        int w;
        w = 0;
        while (grid_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (grid_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: grid_ready=%b want 1", grid_ready);
            return;
        end
        grid_in = g;
        grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
    endtask

    task automatic wait_sel(input logic [7:0] s, input string name);
        int w;
        w = 0;
        while (row_sel !== s && w < 200) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (row_sel !== s) begin
            bad++;
            $display("FAIL %s: got row_sel=%h want %h", name, row_sel, s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_done !== 1'b0 || grid_ready !== 1'b1 ||
            gen_count !== 16'd0 || stable !== 1'b0 || extinct !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got sel=%h data=%h fd=%b rdy=%b gen=%h st=%b ex=%b want 00/00/0/1/0000/0/0",
                     row_sel, col_data, frame_done, grid_ready, gen_count, stable, extinct);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (row_sel !== 8'h00 || grid_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_blank: got sel=%h rdy=%b want 00/1", row_sel, grid_ready);
        end
    endtask

    task automatic test_first_grid();
        grid_in = G1;
        grid_valid = 1'b1;
        @(posedge clk);
        #1;
        grid_valid = 1'b0;
        total++;
        if (grid_ready !== 1'b0 || row_sel !== 8'h00) begin
            bad++;
            $display("FAIL accept_edge: got rdy=%b sel=%h want 0/00", grid_ready, row_sel);
        end
        @(posedge clk);
        #1;
        total++;
        if (row_sel !== 8'h01 || col_data !== 8'h04 || grid_ready !== 1'b1) begin
            bad++;
            $display("FAIL first_row: got sel=%h data=%h rdy=%b want 01/04/1", row_sel, col_data, grid_ready);
        end
        @(negedge clk);
        push_rows(G1, 0, 7);
        drain_all();
    endtask

    task automatic test_frame_period();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        total++;
        if (n != 8 * (RD + 1)) begin
            bad++;
            $display("FAIL frame_period: got %0d want %0d", n, 8 * (RD + 1));
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $display("FAIL frame_pulse_width: got fd=%b want 0", frame_done);
        end
        push_rows(G1, 0, 7);
        drain_all();
    endtask

    task automatic test_mid_frame_swap();
        int w;
        wait_sel(8'h08, "sync_row3");
        total++;
        if (grid_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_offer: got %b want 1", grid_ready);
        end
        grid_in = G2;
        grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
        total++;
        if (grid_ready !== 1'b0 || gen_count !== 16'd2 || stable !== 1'b0) begin
            bad++;
            $display("FAIL mid_accept: got rdy=%b gen=%h st=%b want 0/0002/0", grid_ready, gen_count, stable);
        end
        w = 0;
        while (row_sel === 8'h08 && w < 20) begin
            @(negedge clk);
            w++;
        end
        push_rows(G1, 4, 6);
        drain_all();
        total++;
        if (row_sel !== 8'h80 || col_data !== row_of(G1, 7) || grid_ready !== 1'b0) begin
            bad++;
            $display("FAIL old_row7: got sel=%h data=%h rdy=%b want 80/%h/0", row_sel, col_data, grid_ready, row_of(G1, 7));
        end
        w = 0;
        while (frame_done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (frame_done !== 1'b1 || grid_ready !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: got fd=%b rdy=%b want 1/0", frame_done, grid_ready);
        end
        // Offer on the swap edge itself: must not be taken until the next edge.
        grid_in = 64'd0;
        grid_valid = 1'b1;
        @(negedge clk);
        total++;
        if (row_sel !== 8'h01 || col_data !== 8'hFF || grid_ready !== 1'b1 || gen_count !== 16'd2) begin
            bad++;
            $display("FAIL swap_edge: got sel=%h data=%h rdy=%b gen=%h want 01/ff/1/0002", row_sel, col_data, grid_ready, gen_count);
        end
        @(negedge clk);
        grid_valid = 1'b0;
        total++;
        if (gen_count !== 16'd3 || grid_ready !== 1'b0 || extinct !== 1'b1) begin
            bad++;
            $display("FAIL late_accept: got gen=%h rdy=%b ex=%b want 0003/0/1", gen_count, grid_ready, extinct);
        end
        w = 0;
        while (row_sel === 8'h01 && w < 20) begin
            @(negedge clk);
            w++;
        end
        push_rows(G2, 1, 7);
        drain_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stats();
        logic [15:0] exp_gen [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        logic        exp_ext [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        exp_st  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] grids   [4] = '{64'd0, 64'd0, 64'd1, 64'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            accept(grids[i]);
            total++;
            if (gen_count !== exp_gen[i] || extinct !== exp_ext[i] || stable !== exp_st[i]) begin
                bad++;
                $display("FAIL stats%0d: got gen=%h ex=%b st=%b want %h/%b/%b", i, gen_count, extinct, stable,
                         exp_gen[i], exp_ext[i], exp_st[i]);
            end
            if (i == 1) begin
                repeat (30) @(negedge clk);
                total++;
                if (gen_count !== 16'd2 || extinct !== 1'b1 || stable !== 1'b1) begin
                    bad++;
                    $display("FAIL stats_hold: got gen=%h ex=%b st=%b want 0002/1/1", gen_count, extinct, stable);
                end
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.gen_count_reg = 16'hFFFE;
        #1;
        release dut.gen_count_reg;
        accept(64'h5);
        total++;
        if (gen_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_reach: got %h want ffff", gen_count);
        end
        accept(64'h5);
        total++;
        if (gen_count !== 16'hFFFF || stable !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold: got gen=%h st=%b want ffff/1", gen_count, stable);
        end
    endtask

    task automatic test_reset_midframe();
        int lit;
        accept(G1);
        accept(G2);
        wait_sel(8'h08, "sync_rst_row3");
        total++;
        if (grid_ready !== 1'b0) begin
            bad++;
            $display("FAIL shadow_full_before_rst: got rdy=%b want 0", grid_ready);
        end
        reset = 1'b1;
        #1;
        total++;
        if (row_sel !== 8'h00 || col_data !== 8'h00 || grid_ready !== 1'b1 || gen_count !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: got sel=%h data=%h rdy=%b gen=%h want 00/00/1/0000", row_sel, col_data, grid_ready, gen_count);
        end
        @(negedge clk);
        reset = 1'b0;
        lit = 0;
        repeat (100) begin
            @(negedge clk);
            if (row_sel !== 8'h00 || col_data !== 8'h00) lit++;
        end
        total++;
        if (lit != 0 || grid_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_blank: got lit_cycles=%0d rdy=%b want 0/1", lit, grid_ready);
        end
    endtask

    initial begin
        test_reset();
        test_first_grid();
        test_frame_period();
        test_mid_frame_swap();
        test_stats();
        test_saturation();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
